// File: rtl/cart_bus_pkg.sv
// Shared types and timing defaults for the cartridge CPU bus master.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cart_bus_pkg;

    // Half of an M2 bus cycle: M2 low, then M2 high.
    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    // Default number of clk periods in each M2 phase.
    localparam int M2_LOW_CLKS_DEF  = 3;
    localparam int M2_HIGH_CLKS_DEF = 3;

    // Larger of two ints; used to size the shared phase counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous level input.
// Latency: 2 clk from input change to output change.
// Backpressure: none; samples every clk.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_ff1;
    logic r_ff2;

    // Shift the asynchronous level through two flops to settle metastability.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ff1 <= RST_VAL;
            r_ff2 <= RST_VAL;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end

    assign o_q = r_ff2;

endmodule

// File: rtl/cpu_bus_master.sv
// Generates continuous M2 bus cycles and runs one host request per cycle on the cartridge CPU bus.
// Latency: accept to rsp_valid is M2_LOW_CLKS+M2_HIGH_CLKS clk; irq_sync lags irq_in by 2 clk.
// Backpressure: req_ready only on the last M2-high clk; unaccepted slots become idle cycles.
module cpu_bus_master
    import cart_bus_pkg::*;
#(
    parameter int M2_LOW_CLKS  = M2_LOW_CLKS_DEF,
    parameter int M2_HIGH_CLKS = M2_HIGH_CLKS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_rw,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        m2,
    output logic        romsel,
    output logic        cpu_rw,
    output logic [14:0] cpu_addr,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_oe,
    input  logic [7:0]  cpu_data_in,
    input  logic        irq_in,
    output logic        irq_sync
);

    localparam int CNT_W = $clog2(max_int(M2_LOW_CLKS, M2_HIGH_CLKS) + 1);

    // Phase sequencer state
    phase_t             r_phase;
    phase_t             w_phase_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_last;        // final clk of PH_HIGH: cycle ends on this edge
    logic               w_enter_high;  // final clk of PH_LOW: M2 rises on this edge
    logic               w_accept;

    // Registered bus-cycle context; r_req marks a host request cycle vs. idle
    logic               r_m2;
    logic               r_req;
    logic               r_a15;
    logic [14:0]        r_addr;
    logic               r_rw;
    logic [7:0]         r_wdata;
    logic               r_oe;
    logic [7:0]         r_dout;
    logic               r_rsp_valid;
    logic [7:0]         r_rdata;

    // Phase and counter register; M2 is registered alongside so it is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= PH_LOW;
            r_cnt   <= '0;
            r_m2    <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_m2    <= (w_phase_nxt == PH_HIGH);
        end
    end

    // Next phase/count and the two phase-boundary strobes.
    always_comb begin
        w_phase_nxt  = r_phase;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_last       = 1'b0;
        w_enter_high = 1'b0;
        case (r_phase)
            PH_LOW: begin
                if (r_cnt == CNT_W'(M2_LOW_CLKS - 1)) begin
                    w_phase_nxt  = PH_HIGH;
                    w_cnt_nxt    = '0;
                    w_enter_high = 1'b1;
                end
            end
            PH_HIGH: begin
                if (r_cnt == CNT_W'(M2_HIGH_CLKS - 1)) begin
                    w_phase_nxt = PH_LOW;
                    w_cnt_nxt   = '0;
                    w_last      = 1'b1;
                end
            end
        endcase
    end

    assign req_ready = w_last;
    assign w_accept  = req_valid & w_last;

    // Latch the next cycle's context at the cycle boundary, capture read data and flag completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req       <= 1'b0;
            r_a15       <= 1'b0;
            r_addr      <= '0;
            r_rw        <= 1'b1;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rsp_valid <= w_last & r_req;
            if (w_last) begin
                if (r_req && r_rw) begin
                    r_rdata <= cpu_data_in;
                end
                if (w_accept) begin
                    r_req   <= 1'b1;
                    r_a15   <= req_addr[15];
                    r_addr  <= req_addr[14:0];
                    r_rw    <= req_rw;
                    r_wdata <= req_wdata;
                end else begin
                    r_req   <= 1'b0;
                    r_a15   <= 1'b0;
                    r_addr  <= '0;
                    r_rw    <= 1'b1;
                    r_wdata <= '0;
                end
            end
        end
    end

    // Drive the data bus only while M2 is high in a write request cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oe   <= 1'b0;
            r_dout <= '0;
        end else if (w_enter_high) begin
            r_oe   <= r_req & ~r_rw;
            r_dout <= (r_req & ~r_rw) ? r_wdata : 8'h00;
        end else if (w_last) begin
            r_oe   <= 1'b0;
            r_dout <= '0;
        end
    end

    sync2 #(
        .RST_VAL (1'b1)
    ) u_irq_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (irq_in),
        .o_q   (irq_sync)
    );

    assign m2           = r_m2;
    assign romsel       = ~(r_m2 & r_a15);
    assign cpu_rw       = r_rw;
    assign cpu_addr     = r_addr;
    assign cpu_data_oe  = r_oe;
    assign cpu_data_out = r_dout;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rdata;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master with 3-low/3-high M2 timing.
// Latency: checks accept-to-response of 6 clk and 2 clk IRQ sync delay.
// Backpressure: drives requests only when the bench's cycle position says req_ready is due.
module tb_cpu_bus_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        req_rw;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        m2;
    logic        romsel;
    logic        cpu_rw;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_oe;
    logic [7:0]  cpu_data_in;
    logic        irq_in;
    logic        irq_sync;

    int n_cmp;
    int n_err;
    int pos;   // clk index inside the current 6-clk bus cycle: 0..2 M2 low, 3..5 M2 high

    cpu_bus_master #(
        .M2_LOW_CLKS  (3),
        .M2_HIGH_CLKS (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_rw       (req_rw),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .m2           (m2),
        .romsel       (romsel),
        .cpu_rw       (cpu_rw),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_data_oe  (cpu_data_oe),
        .cpu_data_in  (cpu_data_in),
        .irq_in       (irq_in),
        .irq_sync     (irq_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (pos %0d, t=%0t)", tag, obs, exp, pos, $time);
        end
    endtask

    // Advance one clk; the bench samples and drives on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        pos = (pos == 5) ? 0 : pos + 1;
    endtask

    task automatic goto_pos(input int p);
        for (int k = 0; k < 6 && pos != p; k++) tick();
    endtask

    // One isolated request: issue at the ready slot, check the whole bus cycle, then the response.
    task automatic run_single(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                              input logic [7:0] exp_rdata);
        goto_pos(5);
        req_valid = 1'b1;
        req_addr  = a;
        req_rw    = rw;
        req_wdata = wd;
        chk("ready_at_last_high", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        req_addr  = 16'hFFFF;
        req_wdata = 8'hEE;
        for (int p = 0; p < 6; p++) begin
            chk("req_addr",   {17'd0, cpu_addr}, {17'd0, a[14:0]});
            chk("req_rw",     {31'd0, cpu_rw}, {31'd0, rw});
            chk("req_m2",     {31'd0, m2}, (p >= 3) ? 32'd1 : 32'd0);
            chk("req_romsel", {31'd0, romsel}, (p >= 3 && a[15]) ? 32'd0 : 32'd1);
            chk("req_oe",     {31'd0, cpu_data_oe}, (p >= 3 && !rw) ? 32'd1 : 32'd0);
            if (p >= 3 && !rw) chk("req_dout", {24'd0, cpu_data_out}, {24'd0, wd});
            chk("req_no_rsp", {31'd0, rsp_valid}, 32'd0);
            if (p < 5) tick();
        end
        tick();
        chk("rsp_pulse",  {31'd0, rsp_valid}, 32'd1);
        chk("rsp_rdata",  {24'd0, rsp_rdata}, {24'd0, exp_rdata});
        chk("after_idle_addr", {17'd0, cpu_addr}, 32'd0);
        chk("after_idle_rw",   {31'd0, cpu_rw}, 32'd1);
        tick();
        chk("rsp_one_clk", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        pos         = 0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_addr    = 16'h0000;
        req_rw      = 1'b1;
        req_wdata   = 8'h00;
        cpu_data_in = 8'h00;
        irq_in      = 1'b1;

        // Reset state
        #2;
        chk("rst_m2",     {31'd0, m2}, 32'd0);
        chk("rst_romsel", {31'd0, romsel}, 32'd1);
        chk("rst_rw",     {31'd0, cpu_rw}, 32'd1);
        chk("rst_addr",   {17'd0, cpu_addr}, 32'd0);
        chk("rst_oe",     {31'd0, cpu_data_oe}, 32'd0);
        chk("rst_dout",   {24'd0, cpu_data_out}, 32'd0);
        chk("rst_rsp",    {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata",  {24'd0, rsp_rdata}, 32'd0);
        chk("rst_irq",    {31'd0, irq_sync}, 32'd1);
        chk("rst_ready",  {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pos = 0;

        // Idle bus for 60 clks
        for (int k = 0; k < 60; k++) begin
            chk("idle_m2",     {31'd0, m2}, (pos >= 3) ? 32'd1 : 32'd0);
            chk("idle_ready",  {31'd0, req_ready}, (pos == 5) ? 32'd1 : 32'd0);
            chk("idle_romsel", {31'd0, romsel}, 32'd1);
            chk("idle_rw",     {31'd0, cpu_rw}, 32'd1);
            chk("idle_addr",   {17'd0, cpu_addr}, 32'd0);
            chk("idle_rsp",    {31'd0, rsp_valid}, 32'd0);
            tick();
        end

        // Read $8123 returning $A5
        cpu_data_in = 8'hA5;
        run_single(16'h8123, 1'b1, 8'h00, 8'hA5);

        // Write $5A to $6000; read data register must hold $A5
        cpu_data_in = 8'h33;
        run_single(16'h6000, 1'b0, 8'h5A, 8'hA5);

        // Back-to-back reads at $8000/$8001/$8002 with req_valid held
        goto_pos(5);
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_addr  = 16'h8000;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) req_addr = 16'h8001 + 16'(i);
            else       req_valid = 1'b0;
            chk("b2b_addr", {17'd0, cpu_addr}, 32'(i));
            chk("b2b_rw",   {31'd0, cpu_rw}, 32'd1);
            if (i > 0) begin
                chk("b2b_rsp",   {31'd0, rsp_valid}, 32'd1);
                chk("b2b_rdata", {24'd0, rsp_rdata}, 32'h10 + 32'(i - 1));
            end
            cpu_data_in = 8'h10 + 8'(i);
            for (int p = 1; p < 6; p++) begin
                tick();
                chk("b2b_hold_addr", {17'd0, cpu_addr}, 32'(i));
                chk("b2b_no_rsp",    {31'd0, rsp_valid}, 32'd0);
                chk("b2b_romsel",    {31'd0, romsel}, (p >= 3) ? 32'd0 : 32'd1);
            end
            tick();
        end
        chk("b2b_last_rsp",   {31'd0, rsp_valid}, 32'd1);
        chk("b2b_last_rdata", {24'd0, rsp_rdata}, 32'h12);
        chk("b2b_then_idle",  {17'd0, cpu_addr}, 32'd0);
        chk("b2b_idle_rw",    {31'd0, cpu_rw}, 32'd1);

        // Reset on the 2nd M2-high clk of a write
        goto_pos(5);
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 16'h6000;
        req_wdata = 8'h77;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst_oe",   {31'd0, cpu_data_oe}, 32'd1);
        chk("pre_rst_dout", {24'd0, cpu_data_out}, 32'h77);
        #1 rst = 1'b1;
        #1;
        chk("abort_oe", {31'd0, cpu_data_oe}, 32'd0);
        chk("abort_rw", {31'd0, cpu_rw}, 32'd1);
        chk("abort_m2", {31'd0, m2}, 32'd0);
        chk("abort_romsel", {31'd0, romsel}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        pos = 0;
        for (int k = 0; k < 7; k++) begin
            chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
            chk("abort_idle_rw", {31'd0, cpu_rw}, 32'd1);
            chk("abort_idle_addr", {17'd0, cpu_addr}, 32'd0);
            chk("abort_idle_oe", {31'd0, cpu_data_oe}, 32'd0);
            tick();
        end

        // IRQ synchronizer delay, falling then rising
        irq_in = 1'b0;
        chk("irq_fall_0", {31'd0, irq_sync}, 32'd1);
        tick();
        chk("irq_fall_1", {31'd0, irq_sync}, 32'd1);
        tick();
        chk("irq_fall_2", {31'd0, irq_sync}, 32'd0);
        irq_in = 1'b1;
        chk("irq_rise_0", {31'd0, irq_sync}, 32'd0);
        tick();
        chk("irq_rise_1", {31'd0, irq_sync}, 32'd0);
        tick();
        chk("irq_rise_2", {31'd0, irq_sync}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_bus_master.md
CPU_BUS_MASTER -- requirements
Module: cpu_bus_master

Interface
REQ-001 SHALL have parameter M2_LOW_CLKS, default 3, clk periods per M2-low phase (legal range >=1).
REQ-002 SHALL have parameter M2_HIGH_CLKS, default 3, clk periods per M2-high phase (legal range >=1).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  host has a bus request pending.
REQ-006 SHALL have port req_ready  out  1  request accepted on this edge if req_valid is high.
REQ-007 SHALL have port req_addr  in  16  CPU address $0000-$FFFF.
REQ-008 SHALL have port req_rw  in  1  1 = read, 0 = write.
REQ-009 SHALL have port req_wdata  in  8  write data.
REQ-010 SHALL have port rsp_valid  out  1  one-clk pulse marking completion of a request cycle.
REQ-011 SHALL have port rsp_rdata  out  8  data sampled in a read cycle.
REQ-012 SHALL have ports m2 (out 1), romsel (out 1), cpu_rw (out 1) and cpu_addr (out 15): the cartridge-side CPU bus.
REQ-013 SHALL have ports cpu_data_out (out 8), cpu_data_oe (out 1) and cpu_data_in (in 8): the split data bus.
REQ-014 SHALL have ports irq_in (in 1, cartridge IRQ, active-low, asynchronous) and irq_sync (out 1, synchronized level).

Function
REQ-015 SHALL run bus cycles continuously: PH_LOW for M2_LOW_CLKS clks, then PH_HIGH for M2_HIGH_CLKS clks, then the next cycle; m2 is 0 in PH_LOW and 1 in PH_HIGH, driven from a register.
REQ-016 SHALL assert req_ready combinationally only on the last clk of PH_HIGH (phase counter = M2_HIGH_CLKS-1).
REQ-017 SHALL, on an accepting edge (req_valid & req_ready), latch the request so the next cycle is its bus cycle; cpu_addr = req_addr[14:0] and cpu_rw = req_rw, both held for the whole cycle.
REQ-018 SHALL, on a non-accepting final edge, make the next cycle an idle cycle: cpu_rw=1, cpu_addr=0, A15=0, no response.
REQ-019 SHALL drive romsel = ~(m2 & A15), computed from registered values; romsel is low only during PH_HIGH of cycles with A15=1.
REQ-020 SHALL assert cpu_data_oe with cpu_data_out = wdata only during PH_HIGH of write cycles; cpu_data_oe is 0 otherwise.
REQ-021 SHALL sample cpu_data_in into rsp_rdata on the final PH_HIGH edge of a read request cycle; rsp_rdata holds its value during write and idle cycles.
REQ-022 SHALL pulse rsp_valid for exactly one clk after the final edge of every request cycle, reads and writes alike; accept-to-rsp_valid latency is M2_LOW_CLKS+M2_HIGH_CLKS clks.
REQ-023 SHALL permit acceptance and completion on the same edge, so a held req_valid gives back-to-back request cycles with no idle cycle between them.
REQ-024 SHALL pass irq_in through a 2-flop synchronizer, so irq_sync = irq_in delayed by 2 clks.

Reset
REQ-025 SHALL, while rst is high, force: PH_LOW, phase counter 0, m2=0, romsel=1, cpu_rw=1, cpu_addr=0, cpu_data_oe=0, cpu_data_out=0, rsp_valid=0, rsp_rdata=0, irq_sync=1 (synchronizer flops = 1), and the current cycle marked idle.
REQ-026 SHALL abort a cycle in progress when rst asserts: no rsp_valid is produced for it, and the first cycle after reset is idle.

Structure
REQ-027 SHALL place the phase enum (PH_LOW, PH_HIGH) and the default timing constants in the shared package cart_bus_pkg.
REQ-028 SHALL implement the IRQ synchronizer as the single sub-module sync2 (1-bit, reset value parameterized, 1 here).

Verification (M2_LOW_CLKS=3, M2_HIGH_CLKS=3)
REQ-029 SHALL cover the idle bus: no requests for 60 clks -> m2 period 6 clks (3 low, 3 high), romsel=1, cpu_rw=1, cpu_addr=0, rsp_valid never high.
REQ-030 SHALL cover a read at $8123 with cpu_data_in=$A5 -> cpu_addr=$0123, romsel low only during the 3 m2-high clks, rsp_rdata=$A5 with rsp_valid 6 clks after accept.
REQ-031 SHALL cover a write of $5A to $6000 -> cpu_rw=0 for all 6 clks, romsel=1, cpu_data_oe=1 with cpu_data_out=$5A only during m2 high, rsp_valid pulse 6 clks after accept.
REQ-032 SHALL cover req_valid held for reads at $8000/$8001/$8002 -> three consecutive cycles with no idle gap and three rsp_valid pulses 6 clks apart.
REQ-033 SHALL cover rst asserted on the 2nd m2-high clk of a write -> cpu_data_oe=0, cpu_rw=1, m2=0 immediately, no rsp_valid, and the next cycle idle.
REQ-034 SHALL cover irq_in falling -> irq_sync falls exactly 2 clks later; irq_in rising -> irq_sync rises 2 clks later.
